// File: rtl/fpu_add_sub_special_pipe.sv
// fpu_add_sub_special_pipe: two-stage special-case classifier/bypass unit for FP add/sub with sticky flags
module fpu_add_sub_special_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_add_sub,
  input  logic             i_sign_a,
  input  logic [EXP_W-1:0] i_exp_a,
  input  logic [MAN_W-1:0] i_man_a,
  input  logic             i_sign_b,
  input  logic [EXP_W-1:0] i_exp_b,
  input  logic [MAN_W-1:0] i_man_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_bypass,
  output logic             o_res_sign,
  output logic [EXP_W-1:0] o_res_exp,
  output logic [MAN_W-1:0] o_res_man,
  output logic [2:0]       o_class_a,
  output logic [2:0]       o_class_b,
  input  logic             i_flag_clr,
  output logic             o_flag_invalid,
  output logic             o_flag_inf
);
  localparam logic [2:0] C_ZERO = 3'd0, C_SUB = 3'd1, C_NORM = 3'd2,
                         C_INF = 3'd3, C_QNAN = 3'd4, C_SNAN = 3'd5;
  localparam logic [MAN_W-1:0] QBIT = {1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [2:0] f_class(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    f_class = (e == '0) ? ((m == '0) ? C_ZERO : C_SUB) :
              (&e)      ? ((m == '0) ? C_INF : m[MAN_W-1] ? C_QNAN : C_SNAN) : C_NORM;
  endfunction

  logic             r_v1, r_v2, r_sa, r_sb;
  logic [EXP_W-1:0] r_ea, r_eb;
  logic [MAN_W-1:0] r_ma, r_mb;
  logic [2:0]       r_ca, r_cb;
  logic             r_byp, r_rs;
  logic [EXP_W-1:0] r_re;
  logic [MAN_W-1:0] r_rm;
  logic [2:0]       r_oca, r_ocb;
  logic             r_finv, r_finf;
  logic             w_s2_load, w_s1_load;
  logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_r3, w_byp, w_sign, w_inv, w_inf;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_s2_load = ~r_v2 | i_ready;
  assign w_s1_load = ~r_v1 | w_s2_load;
  assign o_ready   = w_s1_load;

  // special-case decision on the operands held in S1, in rule priority order
  always_comb begin
    w_nan_a = (r_ca == C_QNAN) | (r_ca == C_SNAN);
    w_nan_b = (r_cb == C_QNAN) | (r_cb == C_SNAN);
    w_inf_a = r_ca == C_INF;
    w_inf_b = r_cb == C_INF;
    w_r3    = ~w_nan_a & ~w_nan_b & w_inf_a & w_inf_b & (r_sa != r_sb);
    w_byp   = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
    w_sign  = w_nan_a ? r_sa : w_nan_b ? r_sb : w_r3 ? 1'b0 : w_inf_a ? r_sa : w_inf_b ? r_sb : 1'b0;
    w_exp   = w_nan_a ? r_ea : w_nan_b ? r_eb : w_byp ? '1 : '0;
    w_man   = w_nan_a ? (r_ma | QBIT) : w_nan_b ? (r_mb | QBIT) : w_r3 ? QBIT : '0;
    w_inv   = w_r3 | (r_ca == C_SNAN) | (r_cb == C_SNAN);
    w_inf   = (w_inf_a | w_inf_b) & ~w_nan_a & ~w_nan_b & ~w_r3;
  end

  // S1: capture operands, effective sign of B and operand classes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_ea <= '0;
      r_eb <= '0;
      r_ma <= '0;
      r_mb <= '0;
      r_ca <= C_ZERO;
      r_cb <= C_ZERO;
    end else if (w_s1_load) begin
      r_v1 <= i_valid;
      r_sa <= i_sign_a;
      r_sb <= i_sign_b ^ i_add_sub;
      r_ea <= i_exp_a;
      r_eb <= i_exp_b;
      r_ma <= i_man_a;
      r_mb <= i_man_b;
      r_ca <= f_class(i_exp_a, i_man_a);
      r_cb <= f_class(i_exp_b, i_man_b);
    end
  end

  // S2: register the special result; holds while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2  <= 1'b0;
      r_byp <= 1'b0;
      r_rs  <= 1'b0;
      r_re  <= '0;
      r_rm  <= '0;
      r_oca <= C_ZERO;
      r_ocb <= C_ZERO;
    end else if (w_s2_load) begin
      r_v2  <= r_v1;
      r_byp <= w_byp;
      r_rs  <= w_sign;
      r_re  <= w_exp;
      r_rm  <= w_man;
      r_oca <= r_ca;
      r_ocb <= r_cb;
    end
  end

  // sticky flags set as a result enters S2; a set wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_finv <= 1'b0;
      r_finf <= 1'b0;
    end else begin
      r_finv <= (w_s2_load & r_v1 & w_inv) | (r_finv & ~i_flag_clr);
      r_finf <= (w_s2_load & r_v1 & w_inf) | (r_finf & ~i_flag_clr);
    end
  end

  assign o_valid        = r_v2;
  assign o_bypass       = r_byp;
  assign o_res_sign     = r_rs;
  assign o_res_exp      = r_re;
  assign o_res_man      = r_rm;
  assign o_class_a      = r_oca;
  assign o_class_b      = r_ocb;
  assign o_flag_invalid = r_finv;
  assign o_flag_inf     = r_finf;
endmodule

// File: tb/tb_fpu_add_sub_special_pipe.sv
// tb_fpu_add_sub_special_pipe: random and directed checks against a rule-level reference model
module tb_fpu_add_sub_special_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_valid = 0, i_add_sub = 0, i_sign_a = 0, i_sign_b = 0, i_ready = 0, i_flag_clr = 0;
  logic [7:0]  i_exp_a = 0, i_exp_b = 0;
  logic [22:0] i_man_a = 0, i_man_b = 0;
  logic        o_ready, o_valid, o_bypass, o_res_sign, o_flag_invalid, o_flag_inf;
  logic [7:0]  o_res_exp;
  logic [22:0] o_res_man;
  logic [2:0]  o_class_a, o_class_b;

  fpu_add_sub_special_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_add_sub(i_add_sub),
    .i_sign_a(i_sign_a), .i_exp_a(i_exp_a), .i_man_a(i_man_a),
    .i_sign_b(i_sign_b), .i_exp_b(i_exp_b), .i_man_b(i_man_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_bypass(o_bypass), .o_res_sign(o_res_sign),
    .o_res_exp(o_res_exp), .o_res_man(o_res_man), .o_class_a(o_class_a), .o_class_b(o_class_b),
    .i_flag_clr(i_flag_clr), .o_flag_invalid(o_flag_invalid), .o_flag_inf(o_flag_inf));

  logic        h_valid = 0, h_add_sub = 0, h_sign_a = 0, h_sign_b = 0, h_ready = 1, h_flag_clr = 0;
  logic [4:0]  h_exp_a = 0, h_exp_b = 0;
  logic [9:0]  h_man_a = 0, h_man_b = 0;
  logic        h_o_ready, h_o_valid, h_o_bypass, h_o_res_sign, h_o_flag_invalid, h_o_flag_inf;
  logic [4:0]  h_o_res_exp;
  logic [9:0]  h_o_res_man;
  logic [2:0]  h_o_class_a, h_o_class_b;

  fpu_add_sub_special_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(h_valid), .o_ready(h_o_ready), .i_add_sub(h_add_sub),
    .i_sign_a(h_sign_a), .i_exp_a(h_exp_a), .i_man_a(h_man_a),
    .i_sign_b(h_sign_b), .i_exp_b(h_exp_b), .i_man_b(h_man_b),
    .o_valid(h_o_valid), .i_ready(h_ready), .o_bypass(h_o_bypass), .o_res_sign(h_o_res_sign),
    .o_res_exp(h_o_res_exp), .o_res_man(h_o_res_man), .o_class_a(h_o_class_a), .o_class_b(h_o_class_b),
    .i_flag_clr(h_flag_clr), .o_flag_invalid(h_o_flag_invalid), .o_flag_inf(h_o_flag_inf));

  typedef struct {
    logic        byp, s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [2:0]  ca, cb;
    logic        inv, inf;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0, cyc = 0;
  logic        m_inv = 0, m_inf = 0, hold = 0;
  logic [39:0] held;
  localparam logic [22:0] Q32 = 23'h400000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] cls(input logic [7:0] e, input logic [22:0] m);
    if (e == 8'h00) return (m == 0) ? 3'd0 : 3'd1;
    if (e != 8'hFF) return 3'd2;
    if (m == 0) return 3'd3;
    return m[22] ? 3'd4 : 3'd5;
  endfunction

  function automatic exp_t ref32(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                                 input logic sbr, input logic [7:0] eb, input logic [22:0] mb, input logic op);
    exp_t r;
    logic sb = sbr ^ op;
    r = '{byp: 0, s: 0, e: 0, m: 0, ca: cls(ea, ma), cb: cls(eb, mb), inv: 0, inf: 0, acc: 0};
    if (r.ca >= 4) begin r.byp = 1; r.s = sa; r.e = ea; r.m = ma | Q32; end
    else if (r.cb >= 4) begin r.byp = 1; r.s = sb; r.e = eb; r.m = mb | Q32; end
    else if (r.ca == 3 && r.cb == 3 && sa != sb) begin r.byp = 1; r.e = 8'hFF; r.m = Q32; r.inv = 1; end
    else if (r.ca == 3) begin r.byp = 1; r.s = sa; r.e = 8'hFF; r.inf = 1; end
    else if (r.cb == 3) begin r.byp = 1; r.s = sb; r.e = 8'hFF; r.inf = 1; end
    if (r.ca == 5 || r.cb == 5) r.inv = 1;
    return r;
  endfunction

  function automatic logic [39:0] outw();
    return {o_valid, o_bypass, o_res_sign, o_res_exp, o_res_man, o_class_a, o_class_b};
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    if (hold) chk("hold_stable", outw(), held);
    chk("o_ready", o_ready, (q.size() < 2) || i_ready);
    chk("o_valid", o_valid, q.size() > 0 && cyc - q[0].acc >= 2);
    if (o_valid && i_ready) begin
      if (q.size() == 0) chk("extra_output", o_valid, 0);
      else begin
        e = q.pop_front();
        chk("result", {o_bypass, o_res_sign, o_res_exp, o_res_man, o_class_a, o_class_b},
            {e.byp, e.s, e.e, e.m, e.ca, e.cb});
        m_inv |= e.inv;
        m_inf |= e.inf;
      end
    end
    if (q.size() == 0) chk("flags", {o_flag_invalid, o_flag_inf}, {m_inv, m_inf});
    hold = o_valid && !i_ready;
    held = outw();
    if (i_valid && o_ready) begin
      e = ref32(i_sign_a, i_exp_a, i_man_a, i_sign_b, i_exp_b, i_man_b, i_add_sub);
      e.acc = cyc;
      q.push_back(e);
    end
    if (i_flag_clr) begin m_inv = 0; m_inf = 0; end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_ops(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                         input logic sb, input logic [7:0] eb, input logic [22:0] mb, input logic op);
    i_sign_a = sa; i_exp_a = ea; i_man_a = ma;
    i_sign_b = sb; i_exp_b = eb; i_man_b = mb; i_add_sub = op;
  endtask

  task automatic op(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                    input logic sb, input logic [7:0] eb, input logic [22:0] mb, input logic as);
    set_ops(sa, ea, ma, sb, eb, mb, as);
    i_valid = 1;
    tick();
    i_valid = 0;
  endtask

  function automatic logic [7:0] rexp();
    case ($urandom_range(3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [22:0] rman();
    case ($urandom_range(3))
      0: return 23'h0;
      1: return Q32 | 23'($urandom_range(7));
      2: return 23'($urandom_range(1, 3));
      default: return 23'($urandom);
    endcase
  endfunction

  task automatic rand_ops();
    set_ops(1'($urandom), rexp(), rman(), 1'($urandom), rexp(), rman(), 1'($urandom));
  endtask

  task automatic drain();
    i_valid = 0;
    i_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_valid", {o_valid, o_bypass, o_res_sign, o_res_exp, o_res_man}, 0);
    chk("rst_class_flags", {o_class_a, o_class_b, o_flag_invalid, o_flag_inf}, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    i_ready = 1;
    @(negedge clk);

    op(0, 8'h7F, 0, 1, 8'h80, 0, 0);
    chk("lat_1cycle", o_valid, 0);
    tick();
    chk("lat_2cycle", {o_valid, o_bypass, o_class_a, o_class_b}, {1'b1, 1'b0, 3'd2, 3'd2});
    chk("normal_flags", {o_flag_invalid, o_flag_inf}, 0);
    tick();

    op(0, 8'hFF, 0, 0, 8'hFF, 0, 1);
    tick();
    chk("inf_minus_inf", {o_bypass, o_res_sign, o_res_exp, o_res_man}, {1'b1, 1'b0, 8'hFF, 23'h400000});
    tick();
    chk("invalid_set", o_flag_invalid, 1);

    op(0, 8'hFF, 23'h1, 0, 8'h7F, 0, 0);
    tick();
    chk("snan_a", {o_bypass, o_res_exp, o_res_man, o_class_a}, {1'b1, 8'hFF, 23'h400001, 3'd5});
    tick();

    op(0, 8'h7F, 0, 0, 8'hFF, 0, 1);
    tick();
    chk("one_minus_inf", {o_bypass, o_res_sign, o_res_exp, o_res_man}, {1'b1, 1'b1, 8'hFF, 23'h0});
    tick();
    chk("flags_sticky", {o_flag_invalid, o_flag_inf}, 2'b11);
    i_flag_clr = 1;
    tick();
    i_flag_clr = 0;
    chk("flags_cleared", {o_flag_invalid, o_flag_inf}, 0);

    for (int i = 0; i < 8; i++) begin
      rand_ops();
      i_valid = 1;
      i_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      rand_ops();
      i_valid = $urandom_range(3) != 0;
      i_ready = $urandom_range(2) != 0;
      tick();
    end
    drain();

    h_sign_a = 0; h_exp_a = 5'h1F; h_man_a = 0;
    h_sign_b = 0; h_exp_b = 5'h1F; h_man_b = 0; h_add_sub = 1;
    h_valid = 1;
    @(posedge clk);
    #1 h_valid = 0;
    chk("fp16_lat1", h_o_valid, 0);
    @(posedge clk);
    #1;
    chk("fp16_inf_minus_inf", {h_o_valid, h_o_bypass, h_o_res_sign, h_o_res_exp, h_o_res_man},
        {1'b1, 1'b1, 1'b0, 5'h1F, 10'h200});
    chk("fp16_class_flag", {h_o_class_a, h_o_class_b, h_o_flag_invalid}, {3'd3, 3'd3, 1'b1});
    @(negedge clk);

    i_ready = 0;
    op(0, 8'hFF, 0, 1, 8'hFF, 0, 0);
    op(1, 8'h7F, 23'h5, 0, 8'h00, 23'h3, 0);
    chk("inflight_valid", {o_valid, o_flag_invalid, o_ready}, 3'b110);
    #2 rst_n = 0;
    #1;
    chk("mid_reset", {o_valid, o_bypass, o_flag_invalid, o_flag_inf}, 0);
    chk("mid_reset_ready", o_ready, 1);
    chk("fp16_mid_reset", {h_o_valid, h_o_flag_invalid, h_o_flag_inf}, 0);
    q.delete();
    m_inv = 0;
    m_inf = 0;
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    i_ready = 1;
    op(0, 8'hFF, 23'h2, 0, 8'h7F, 0, 0);
    chk("post_reset_lat1", o_valid, 0);
    tick();
    chk("post_reset_lat2", {o_valid, o_bypass, o_res_man}, {1'b1, 1'b1, 23'h400002});
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_add_sub_special_pipe.md
Name: fpu_add_sub_special_pipe

Overview:
- Pipelined, parametrised special-case unit for the FP add/sub datapath.
- Classifies both operands (zero, subnormal, normal, infinity, quiet NaN, signalling NaN) for any exponent/fraction width.
- Decides whether the result bypasses the main adder; when it does, it builds the full special result word.
- Adds valid/ready backpressure and sticky exception flags, feeding the FFT butterfly FPU lanes.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (no hidden bit); MSB of the fraction is the quiet bit.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  unit can accept input this cycle.
- i_add_sub  in  1  0 = A+B, 1 = A−B.
- i_sign_a  in  1  sign of A.
- i_exp_a  in  EXP_W  exponent of A.
- i_man_a  in  MAN_W  fraction of A.
- i_sign_b  in  1  sign of B.
- i_exp_b  in  EXP_W  exponent of B.
- i_man_b  in  MAN_W  fraction of B.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_bypass  out  1  result is special; downstream must use o_res_* and skip the adder.
- o_res_sign  out  1  special result sign.
- o_res_exp  out  EXP_W  special result exponent.
- o_res_man  out  MAN_W  special result fraction.
- o_class_a  out  3  class of A: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
- o_class_b  out  3  class of B, same encoding.
- i_flag_clr  in  1  clear sticky flags.
- o_flag_invalid  out  1  sticky invalid flag.
- o_flag_inf  out  1  sticky "infinite result produced" flag.

Behaviour:
- Reset: all stage valids, o_valid, o_bypass, o_res_*, o_class_*, and both flags are 0. Only the ready chain is combinational.
- Classification:
  - E1 = exponent all ones; E0 = exponent zero; M0 = fraction zero; Q = fraction MSB.
  - zero = E0&M0; subnormal = E0&~M0; inf = E1&M0; qNaN = E1&Q; sNaN = E1&~M0&~Q; otherwise normal.
- Effective sign of B: sb = i_sign_b ^ i_add_sub.
- Result rules, in priority order:
  1. A is NaN → bypass; result = A with the quiet bit forced to 1.
  2. Else B is NaN → bypass; result = B with the quiet bit forced to 1 and sign sb.
  3. Both inf with i_sign_a != sb → bypass; canonical qNaN (sign 0, exp all ones, fraction = 1 << (MAN_W−1)); raise invalid.
  4. A inf → {i_sign_a, all ones, 0}.
  5. B inf → {sb, all ones, 0}.
  6. Otherwise o_bypass = 0 and o_res_* = 0.
- Invalid is also raised when either input is an sNaN.
- Inf flag is raised for rules 4 and 5.
- Pipeline: two register stages.
  - S1 holds the captured operands and classes.
  - S2 holds the results; o_* are driven from S2.
  - Latency is 2 cycles from input handshake to o_valid when i_ready is held high.
- Handshake:
  - Input is accepted when i_valid & o_ready.
  - o_valid/o_* hold stable while o_valid & ~i_ready.
  - S2 loads when it is empty or i_ready; S1 loads when it is empty or S2 loads.
  - o_ready = ~S1valid | S2 loads.
  - Full throughput: one op/cycle with i_ready high.
  - No bubbles are inserted and no data is lost or duplicated under any i_ready pattern.
- Sticky flags:
  - Updated when a result enters S2 (not at input acceptance).
  - Set has priority over i_flag_clr in the same cycle; otherwise i_flag_clr zeroes both flags the next cycle.
  - Flags are not cleared by backpressure.
- Reset mid-operation: in-flight ops are discarded and flags are cleared; the first valid after release behaves as from idle.

Test Plan:
- FP32, +1.0 (0,0x7F,0) + (−2.0) with i_ready=1 → o_valid exactly 2 cycles later; o_bypass=0; classes 2/2; flags 0.
- +inf (0,0xFF,0) − (+inf), i_add_sub=1 → o_bypass=1; res = {0,0xFF,0x400000}; o_flag_invalid=1, stays 1 until i_flag_clr.
- A = sNaN (0,0xFF,0x000001) + 1.0 → res fraction 0x400001, exp 0xFF; class_a=5; invalid=1.
- 1.0 − (+inf) → res = {1,0xFF,0}; o_flag_inf=1.
- Back-to-back 8 ops with i_ready toggling 1,0,0,1,… → outputs in order, none lost or repeated; o_ready drops only when both stages are full.
- Assert i_rst_n=0 with two ops in flight → o_valid=0 and flags=0 immediately; repeat with EXP_W=5, MAN_W=10 (FP16): inf−inf → {0,0x1F,0x200}.
